// File: rtl/clk_phase_dds_pkg.sv
// -----------------------------------------------------------------------------
// clk_phase_dds_pkg
//   Shared definitions for the master-clock strobe generator:
//     - reset constant for the clk/2 strobe pair
//     - standard DDS increments for a 28 MHz master clock with ACC_W=16
//     - config handshake state type
//     - channel-select width helper (at least one bit even for NCH=1)
// -----------------------------------------------------------------------------
package clk_phase_dds_pkg;

  // {f1,f0} after reset: f0 high first.
  localparam logic [1:0] F_RST = 2'b01;

  // f_out = 28 MHz * inc / 2^16
  localparam int unsigned INC_1M75   = 4096;
  localparam int unsigned INC_1M7734 = 4151;
  localparam int unsigned INC_3M5    = 8192;
  localparam int unsigned INC_3M5469 = 8302;

  // Config handshake: idle, or holding one pending write until the ring wraps.
  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_e;

  // Channel select width; a single channel still gets a 1-bit port.
  function automatic int cw_of(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/clk_phase_dds_ch.sv
// -----------------------------------------------------------------------------
// clk_dds_ch
//   One DDS clock channel: increment register, phase accumulator, clock output
//   (accumulator MSB) and a one-cycle strobe on each rising edge of that clock.
//
// Ports
//   clk_i     master clock, posedge
//   rst_i     synchronous reset, active high (inc=0 -> channel stopped)
//   load_i    load inc_i into the increment register this cycle
//   inc_i     new increment
//   ch_clk_o  accumulator MSB (~50% duty)
//   ch_stb_o  registered pulse, high the cycle after ch_clk_o rises
// -----------------------------------------------------------------------------
module clk_dds_ch #(
  parameter int ACC_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [ACC_W-1:0] inc_i,
  output logic             ch_clk_o,
  output logic             ch_stb_o
);

  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             clk_dly_q;
  logic             stb_q, stb_d;

  // The accumulator keeps its phase across an increment change; the old
  // increment is still added on the load edge, the new one from then on.
  always_comb begin
    inc_d = load_i ? inc_i : inc_q;
    acc_d = acc_q + inc_q;
    stb_d = acc_q[ACC_W-1] & ~clk_dly_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inc_q     <= '0;
      acc_q     <= '0;
      clk_dly_q <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      inc_q     <= inc_d;
      acc_q     <= acc_d;
      clk_dly_q <= acc_q[ACC_W-1];
      stb_q     <= stb_d;
    end
  end

  assign ch_clk_o = acc_q[ACC_W-1];
  assign ch_stb_o = stb_q;

endmodule

// File: rtl/clk_phase_dds.sv
// -----------------------------------------------------------------------------
// clk_phase_dds
//   Master-clock strobe generator. Produces a complementary clk/2 pair, a
//   PHASES-long one-hot phase ring and NCH phase-accumulator clock channels.
//   Channel increments are written through a one-deep pending register and
//   only take effect on the ring wrap cycle, so channel clocks never glitch.
//
// Optional feature macro: CLKGEN_SNAPSHOT_EN
//   Adds snap_o, a once-per-ring coherent picture of f1 and ch_clk[0]. Without
//   the macro the port and its logic are absent.
//
// Ports
//   clk_i       master clock, posedge
//   rst_i       synchronous reset, active high
//   cfg_we_i    config write strobe
//   cfg_ch_i    target channel (values >= NCH accepted but change nothing)
//   cfg_inc_i   new increment for cfg_ch_i
//   cfg_busy_o  a write is pending and not yet applied
//   f0_o, f1_o  complementary clk/2 strobes, f0 high first after reset
//   ph_o        one-hot phase strobes, ph[0] first after reset
//   ph_wrap_o   ph[PHASES-1]; config is applied on this cycle
//   ch_clk_o    per-channel DDS clock
//   ch_stb_o    per-channel rising-edge strobe
//   snap_o      phase snapshot (CLKGEN_SNAPSHOT_EN only)
// -----------------------------------------------------------------------------
module clk_phase_dds
  import clk_phase_dds_pkg::*;
#(
  parameter int PHASES = 4,
  parameter int NCH    = 2,
  parameter int ACC_W  = 16,
  localparam int CW    = cw_of(NCH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_we_i,
  input  logic [CW-1:0]     cfg_ch_i,
  input  logic [ACC_W-1:0]  cfg_inc_i,
  output logic              cfg_busy_o,
  output logic              f0_o,
  output logic              f1_o,
  output logic [PHASES-1:0] ph_o,
  output logic              ph_wrap_o,
  output logic [NCH-1:0]    ch_clk_o,
  output logic [NCH-1:0]    ch_stb_o
`ifdef CLKGEN_SNAPSHOT_EN
  ,
  output logic [2*PHASES-1:0] snap_o
`endif
);

  localparam logic [PHASES-1:0] PH_RST = PHASES'(1);

  typedef struct packed {
    logic [CW-1:0]    ch;
    logic [ACC_W-1:0] inc;
  } cfg_req_t;

  logic [1:0]        f_q, f_d;
  logic [PHASES-1:0] ph_q, ph_d;
  cfg_state_e        state_q, state_d;
  cfg_req_t          pend_q, pend_d;
  logic              apply;
  logic [NCH-1:0]    load;

  // ---------------------------------------------------------------------------
  // clk/2 pair and phase ring
  // ---------------------------------------------------------------------------
  always_comb begin
    f_d  = ~f_q;
    ph_d = {ph_q[PHASES-2:0], ph_q[PHASES-1]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f_q  <= F_RST;
      ph_q <= PH_RST;
    end else begin
      f_q  <= f_d;
      ph_q <= ph_d;
    end
  end

  assign f0_o      = f_q[0];
  assign f1_o      = f_q[1];
  assign ph_o      = ph_q;
  assign ph_wrap_o = ph_q[PHASES-1];

  // ---------------------------------------------------------------------------
  // Config handshake. A write is only captured from idle, so a write arriving
  // on the wrap cycle itself waits a full ring, and anything written while a
  // request is pending (including on the apply cycle) is dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    apply   = 1'b0;
    unique case (state_q)
      CFG_IDLE: begin
        if (cfg_we_i) begin
          pend_d  = '{ch: cfg_ch_i, inc: cfg_inc_i};
          state_d = CFG_PEND;
        end
      end
      CFG_PEND: begin
        if (ph_wrap_o) begin
          apply   = 1'b1;
          state_d = CFG_IDLE;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CFG_IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  assign cfg_busy_o = (state_q == CFG_PEND);

  // Out-of-range channel numbers match no lane, so the write just cycles busy.
  always_comb begin
    load = '0;
    for (int i = 0; i < NCH; i++) begin
      load[i] = apply && (pend_q.ch == CW'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // DDS channels
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_dds_ch #(
      .ACC_W (ACC_W)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (load[g]),
      .inc_i    (pend_q.inc),
      .ch_clk_o (ch_clk_o[g]),
      .ch_stb_o (ch_stb_o[g])
    );
  end

`ifdef CLKGEN_SNAPSHOT_EN
  // ---------------------------------------------------------------------------
  // Snapshot: each ring position k deposits f1 and ch_clk[0] into snap_tmp,
  // and the whole picture is published on ph[0], one ring late but coherent.
  // ---------------------------------------------------------------------------
  logic [2*PHASES-1:0] snap_tmp_q;
  logic [2*PHASES-1:0] snap_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_tmp_q <= '0;
      snap_q     <= '0;
    end else begin
      for (int k = 0; k < PHASES; k++) begin
        if (ph_q[k]) begin
          snap_tmp_q[2*PHASES-1-k] <= f_q[1];
          snap_tmp_q[PHASES-1-k]   <= ch_clk_o[0];
        end
      end
      if (ph_q[0]) snap_q <= snap_tmp_q;
    end
  end

  assign snap_o = snap_q;
`endif

endmodule

// File: tb/tb_clk_phase_dds.sv
// -----------------------------------------------------------------------------
// tb_clk_phase_dds
//   Self-checking bench for clk_phase_dds. A behavioural model tracks cycle
//   count since reset, accumulators as plain modular sums, and the pending
//   write as a flag plus saved request. Inputs change and outputs are sampled
//   on the falling edge.
// -----------------------------------------------------------------------------
module tb_clk_phase_dds;

  localparam int PHASES = 4;
  localparam int NCH    = 2;
  localparam int ACC_W  = 16;
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned MOD = 1 << ACC_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [CW-1:0]     cfg_ch = '0;
  logic [ACC_W-1:0]  cfg_inc = '0;
  logic              cfg_busy, f0, f1, ph_wrap;
  logic [PHASES-1:0] ph;
  logic [NCH-1:0]    ch_clk, ch_stb;
`ifdef CLKGEN_SNAPSHOT_EN
  logic [2*PHASES-1:0] snap;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_phase_dds #(
    .PHASES (PHASES),
    .NCH    (NCH),
    .ACC_W  (ACC_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_we_i   (cfg_we),
    .cfg_ch_i   (cfg_ch),
    .cfg_inc_i  (cfg_inc),
    .cfg_busy_o (cfg_busy),
    .f0_o       (f0),
    .f1_o       (f1),
    .ph_o       (ph),
    .ph_wrap_o  (ph_wrap),
    .ch_clk_o   (ch_clk),
    .ch_stb_o   (ch_stb)
`ifdef CLKGEN_SNAPSHOT_EN
    ,
    .snap_o     (snap)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int unsigned m_t;
  bit          m_busy;
  int unsigned m_pch, m_pinc;
  int unsigned m_inc [NCH];
  int unsigned m_acc [NCH];
  bit          m_prev[NCH];
  bit          m_stb [NCH];
  bit          m_wrap;
`ifdef CLKGEN_SNAPSHOT_EN
  bit                  h_f1[PHASES];
  bit                  h_c0[PHASES];
  logic [2*PHASES-1:0] m_snap;
`endif

  function automatic bit msb(input int unsigned a);
    return a[ACC_W-1];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_busy = 0; m_pch = 0; m_pinc = 0;
      for (int i = 0; i < NCH; i++) begin
        m_inc[i] = 0; m_acc[i] = 0; m_prev[i] = 0; m_stb[i] = 0;
      end
`ifdef CLKGEN_SNAPSHOT_EN
      m_snap = '0;
      for (int k = 0; k < PHASES; k++) begin h_f1[k] = 0; h_c0[k] = 0; end
`endif
    end else begin
      m_wrap = (m_t % PHASES) == PHASES - 1;
`ifdef CLKGEN_SNAPSHOT_EN
      if (m_t % PHASES == 0)
        for (int k = 0; k < PHASES; k++) begin
          m_snap[2*PHASES-1-k] = h_f1[k];
          m_snap[PHASES-1-k]   = h_c0[k];
        end
      h_f1[m_t % PHASES] = (m_t % 2) == 1;
      h_c0[m_t % PHASES] = msb(m_acc[0]);
`endif
      for (int i = 0; i < NCH; i++) begin
        m_stb[i]  = msb(m_acc[i]) && !m_prev[i];
        m_prev[i] = msb(m_acc[i]);
        m_acc[i]  = (m_acc[i] + m_inc[i]) % MOD;
      end
      if (m_busy) begin
        if (m_wrap) begin
          if (m_pch < NCH) m_inc[m_pch] = m_pinc;
          m_busy = 0;
        end
      end else if (cfg_we) begin
        m_pch = cfg_ch; m_pinc = cfg_inc; m_busy = 1;
      end
      m_t++;
    end
  end

  function automatic logic [NCH-1:0] exp_clk();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = msb(m_acc[i]);
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_stb();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = m_stb[i];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    rst = 1'b1; cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int unsigned inc);
    cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_inc = ACC_W'(inc);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int n = 0; n < 4*PHASES; n++) begin
      if (!cfg_busy) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [PHASES-1:0] eph;
    do_reset();
    checks++;
    if (ph !== PHASES'(1) || f0 !== 1'b1 || f1 !== 1'b0 || cfg_busy !== 1'b0 ||
        ch_clk !== '0 || ch_stb !== '0) begin
      failures++;
      $display("FAIL reset_state: ph=%b f0=%b f1=%b busy=%b clk=%b stb=%b, want ph=0001 f0=1 f1=0 rest 0",
               ph, f0, f1, cfg_busy, ch_clk, ch_stb);
    end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      eph = PHASES'(1) << (k % PHASES);
      checks++;
      if (ph !== eph || f0 !== (k % 2 == 0) || f1 !== (k % 2 == 1) ||
          ph_wrap !== (k % PHASES == PHASES-1) || ch_clk !== '0 || ch_stb !== '0) begin
        failures++;
        $display("FAIL reset_seq k=%0d: ph=%b f0=%b f1=%b wrap=%b clk=%b stb=%b, want ph=%b f0=%0d",
                 k, ph, f0, f1, ph_wrap, ch_clk, ch_stb, eph, (k % 2 == 0));
      end
    end
  endtask

  task automatic test_inc4096();
    bit ok; int last, n, bad, hi;
    do_reset();
    cfg_write(0, 4096);
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL inc4096_apply: busy=%b, want 0 within ring", cfg_busy); end
    last = -1; n = 0; bad = 0; hi = 0;
    for (int c = 0; c < 200; c++) begin
      if (ch_stb[1]) bad++;
      if (c < 160) hi += int'(ch_clk[0]);
      if (ch_stb[0]) begin
        if (last >= 0 && c - last != 16) bad++;
        last = c; n++;
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL inc4096_spacing: bad=%0d want 0", bad); end
    checks++;
    if (n != 12) begin failures++; $display("FAIL inc4096_count: got %0d want 12", n); end
    checks++;
    if (hi != 80) begin failures++; $display("FAIL inc4096_duty: high=%0d want 80", hi); end
  endtask

  task automatic test_count4151();
    bit ok; int last, n, bad;
    do_reset();
    cfg_write(1, 4151);
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL inc4151_apply: busy=%b want 0", cfg_busy); end
    last = -1; n = 0; bad = 0;
    for (int c = 0; c < 65536; c++) begin
      if (ch_stb[0]) bad++;
      if (ch_stb[1]) begin
        if (last >= 0 && (c - last < 15 || c - last > 16)) bad++;
        last = c; n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 4151) begin failures++; $display("FAIL inc4151_count: got %0d want 4151", n); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL inc4151_spacing: bad=%0d want 0", bad); end
  endtask

  task automatic test_back_to_back();
    bit ok, prev_wrap; int last, n, bad, busy_seen;
    do_reset();
    cfg_we = 1'b1; cfg_ch = '0; cfg_inc = 16'd8192;
    @(negedge clk);
    checks++;
    if (cfg_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b want 1", cfg_busy); end
    cfg_inc = 16'd100;
    @(negedge clk);
    cfg_we = 1'b0;
    ok = 0; prev_wrap = 0;
    for (int k = 0; k < 4*PHASES; k++) begin
      if (!cfg_busy) begin ok = 1; break; end
      prev_wrap = ph_wrap;
      @(negedge clk);
    end
    checks++;
    if (!ok || !prev_wrap) begin
      failures++; $display("FAIL b2b_drop: dropped=%0d after_wrap=%0d want 1 1", ok, prev_wrap);
    end
    last = -1; n = 0; bad = 0; busy_seen = 0;
    for (int c = 0; c < 64; c++) begin
      if (cfg_busy) busy_seen++;
      if (ch_stb[0]) begin
        if (last >= 0 && c - last != 8) bad++;
        last = c; n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 8 || bad != 0) begin
      failures++; $display("FAIL b2b_rate: pulses=%0d bad=%0d want 8 0", n, bad);
    end
    checks++;
    if (busy_seen != 0) begin failures++; $display("FAIL b2b_second_ignored: busy cycles=%0d want 0", busy_seen); end
  endtask

  task automatic test_wrap_write();
    bit ok; int cnt, bad;
    do_reset();
    ok = 0;
    for (int k = 0; k < 2*PHASES; k++) begin
      if (ph_wrap) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL wrap_find: ph_wrap never seen"); end
    cfg_write(1, $urandom_range(1, 32767));
    cnt = 0;
    for (int k = 0; k < 4*PHASES; k++) begin
      if (!cfg_busy) break;
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != PHASES) begin failures++; $display("FAIL wrap_latency: busy %0d cycles want %0d", cnt, PHASES); end
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      if (ch_clk !== exp_clk() || ch_stb !== exp_stb()) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL wrap_channel: %0d cycles differ from model", bad); end
  endtask

  task automatic test_random();
    logic [PHASES-1:0] eph;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      eph = PHASES'(1) << (m_t % PHASES);
      checks++;
      if (ph !== eph || f0 !== (m_t % 2 == 0) || f1 !== (m_t % 2 == 1) ||
          ph_wrap !== (m_t % PHASES == PHASES-1) || cfg_busy !== m_busy ||
          ch_clk !== exp_clk() || ch_stb !== exp_stb()) begin
        failures++;
        $display("FAIL random c=%0d: ph=%b busy=%b clk=%b stb=%b f0=%b, want ph=%b busy=%b clk=%b stb=%b",
                 c, ph, cfg_busy, ch_clk, ch_stb, f0, eph, m_busy, exp_clk(), exp_stb());
      end
      if ($urandom_range(0, 5) == 0) begin
        cfg_we  = 1'b1;
        cfg_ch  = CW'($urandom_range(0, NCH-1));
        cfg_inc = ($urandom_range(0, 3) == 0) ? ACC_W'($urandom_range(32768, 65535))
                                              : ACC_W'($urandom_range(0, 8000));
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok; int bad;
    logic [PHASES-1:0] eph;
    do_reset();
    cfg_write(0, 4096);
    wait_idle(ok);
    repeat (40) @(negedge clk);
    cfg_write(1, 1000);
    checks++;
    if (cfg_busy !== 1'b1) begin failures++; $display("FAIL rstmid_pending: busy=%b want 1", cfg_busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ph !== PHASES'(1) || f0 !== 1'b1 || f1 !== 1'b0 || cfg_busy !== 1'b0 ||
        ch_clk !== '0 || ch_stb !== '0) begin
      failures++;
      $display("FAIL rstmid_state: ph=%b f0=%b f1=%b busy=%b clk=%b stb=%b want 0001 1 0 0 0 0",
               ph, f0, f1, cfg_busy, ch_clk, ch_stb);
    end
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 64; c++) begin
      eph = PHASES'(1) << (c % PHASES);
      if (ph !== eph || cfg_busy !== 1'b0 || ch_clk !== '0 || ch_stb !== '0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rstmid_stopped: %0d bad cycles want 0", bad); end
  endtask

`ifdef CLKGEN_SNAPSHOT_EN
  task automatic test_snapshot();
    int bad;
    do_reset();
    cfg_write(0, 8192);
    bad = 0;
    for (int c = 0; c < 8*PHASES; c++) begin
      if (snap !== m_snap) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL snapshot: %0d cycles differ from model", bad); end
  endtask
`endif

  initial begin
    test_reset();
    test_inc4096();
    test_back_to_back();
    test_wrap_write();
    test_reset_mid();
    test_random();
`ifdef CLKGEN_SNAPSHOT_EN
    test_snapshot();
`endif
    test_count4151();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
